// File: rtl/mips7_pkg.sv
// rtl/mips7_pkg.sv - shared mips7 pipeline types, exception codes and helpers
package mips7_pkg;

  localparam int EXC_W_DEF = 4;

  localparam logic [EXC_W_DEF-1:0] EXC_NONE = 4'h0;
  localparam logic [EXC_W_DEF-1:0] EXC_ADEL = 4'h4;
  localparam logic [EXC_W_DEF-1:0] EXC_ADES = 4'h5;
  localparam logic [EXC_W_DEF-1:0] EXC_IBE  = 4'h6;
  localparam logic [EXC_W_DEF-1:0] EXC_DBE  = 4'h7;
  localparam logic [EXC_W_DEF-1:0] EXC_SYS  = 4'h8;
  localparam logic [EXC_W_DEF-1:0] EXC_BP   = 4'h9;
  localparam logic [EXC_W_DEF-1:0] EXC_RI   = 4'hA;
  localparam logic [EXC_W_DEF-1:0] EXC_CPU  = 4'hB;
  localparam logic [EXC_W_DEF-1:0] EXC_OV   = 4'hC;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  // Entry count from the valid bits of the main and skid slots.
  function automatic logic [1:0] occ2(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one bundle register with load enable and valid bit
module pipe_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  // Load wins over clear so a reload in the drain cycle keeps the slot full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline register with optional 2-entry skid
module pipe_stage_skid
  import mips7_pkg::*;
#(
  parameter int DW    = 32,
  parameter int EXC_W = EXC_W_DEF,
  parameter bit SKID  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [DW-1:0]    in_data,
  input  logic             in_bd,
  input  logic [EXC_W-1:0] in_exec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [DW-1:0]    out_data,
  output logic             out_bd,
  output logic [EXC_W-1:0] out_exec,
  output logic [1:0]       occupancy
);

  localparam int BW = 32 + DW + 1 + EXC_W;

  logic [BW-1:0] in_bundle;
  logic [BW-1:0] head;
  logic [BW-1:0] main_d;
  logic          main_load;
  logic          main_clear;
  logic          main_valid;
  logic          drain;

  assign in_bundle = {in_pc, in_data, in_bd, in_exec};
  assign {out_pc, out_data, out_bd, out_exec} = head;
  assign out_valid = main_valid;
  assign drain     = main_valid & out_ready;

  pipe_slot #(.W(BW)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .q     (head),
    .valid (main_valid)
  );

  if (SKID) begin : g_skid
    skid_state_e   state;
    skid_state_e   state_n;
    logic          ready_q;
    logic          accept;
    logic          skid_load;
    logic          skid_clear;
    logic          skid_valid;
    logic [BW-1:0] skid_q;

    assign accept     = in_valid & ready_q & ~flush;
    assign main_d     = (state == ST_TWO) ? skid_q : in_bundle;
    assign main_load  = ~flush & (((state == ST_EMPTY) & accept) |
                                  ((state == ST_ONE) & accept & drain) |
                                  ((state == ST_TWO) & drain));
    assign main_clear = flush | ((state == ST_ONE) & drain & ~accept);
    assign skid_load  = (state == ST_ONE) & accept & ~drain;
    assign skid_clear = flush | ((state == ST_TWO) & drain);
    assign in_ready   = ready_q;
    assign occupancy  = occ2(main_valid, skid_valid);

    pipe_slot #(.W(BW)) u_skid (
      .clk   (clk),
      .reset (reset),
      .load  (skid_load),
      .clear (skid_clear),
      .d     (in_bundle),
      .q     (skid_q),
      .valid (skid_valid)
    );

    always_comb begin
      state_n = state;
      if (flush) begin
        state_n = ST_EMPTY;
      end else begin
        case (state)
          ST_EMPTY: if (accept) state_n = ST_ONE;
          ST_ONE: begin
            if (accept && !drain)      state_n = ST_TWO;
            else if (!accept && drain) state_n = ST_EMPTY;
          end
          ST_TWO:   if (drain) state_n = ST_ONE;
          default:  state_n = ST_EMPTY;
        endcase
      end
    end

    // Ready is registered from the next state, so upstream never sees a path through out_ready.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state   <= ST_EMPTY;
        ready_q <= 1'b0;
      end else begin
        state   <= state_n;
        ready_q <= (state_n != ST_TWO);
      end
    end
  end else begin : g_single
    logic accept;

    assign in_ready   = ~main_valid | out_ready;
    assign accept     = in_valid & in_ready & ~flush;
    assign main_d     = in_bundle;
    assign main_load  = accept;
    assign main_clear = flush | (drain & ~accept);
    assign occupancy  = occ2(main_valid, 1'b0);
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid (SKID=1 and SKID=0)
module tb_pipe_stage_skid;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        bd;
    logic [3:0]  exec;
  } bundle_t;

  typedef struct {
    logic        fl;
    logic        iv;
    logic        ordy;
    logic [31:0] pc;
    logic        ov;
    logic [1:0]  occ;
    logic        rdy;
    logic [31:0] opc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_data;
  logic        in_bd;
  logic [3:0]  in_exec;
  logic        out_ready;

  logic        rdy1, ov1, obd1, rdy0, ov0, obd0;
  logic [31:0] opc1, odata1, opc0, odata0;
  logic [3:0]  oexec1, oexec0;
  logic [1:0]  occ1, occ0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DW(32), .EXC_W(4), .SKID(1'b1)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy1), .in_pc(in_pc), .in_data(in_data),
    .in_bd(in_bd), .in_exec(in_exec),
    .out_valid(ov1), .out_ready(out_ready), .out_pc(opc1), .out_data(odata1),
    .out_bd(obd1), .out_exec(oexec1), .occupancy(occ1)
  );

  pipe_stage_skid #(.DW(32), .EXC_W(4), .SKID(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy0), .in_pc(in_pc), .in_data(in_data),
    .in_bd(in_bd), .in_exec(in_exec),
    .out_valid(ov0), .out_ready(out_ready), .out_pc(opc0), .out_data(odata0),
    .out_bd(obd0), .out_exec(oexec0), .occupancy(occ0)
  );

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic bundle_t mk(input logic [31:0] pc);
    bundle_t b;
    b.pc = pc; b.data = ~pc; b.bd = pc[2]; b.exec = pc[5:2];
    return b;
  endfunction

  task automatic drive(input logic fl, input logic iv, input logic ordy, input bundle_t b);
    flush = fl; in_valid = iv; out_ready = ordy;
    in_pc = b.pc; in_data = b.data; in_bd = b.bd; in_exec = b.exec;
  endtask

  task automatic apply_reset();
    drive(1'b0, 1'b0, 1'b0, '0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t    tbl[10];
    bundle_t q1[$];
    bundle_t q0[$];
    bundle_t b;
    int      n, d;
    logic    r1, r0, iv, fl, ordy;

    tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h0040_0000, 1'b0, 2'd0, 1'b1, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h0040_0004, 1'b1, 2'd1, 1'b1, 32'h0040_0000};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 32'h0040_0008, 1'b1, 2'd2, 1'b0, 32'h0040_0000};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h0040_0008, 1'b1, 2'd2, 1'b0, 32'h0040_0000};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h0040_0008, 1'b1, 2'd1, 1'b1, 32'h0040_0004};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 2'd1, 1'b1, 32'h0040_0008};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h0000_0500, 1'b0, 2'd0, 1'b1, 32'h0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 32'h0000_0504, 1'b1, 2'd1, 1'b1, 32'h0000_0500};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 32'h0000_0508, 1'b1, 2'd2, 1'b0, 32'h0000_0500};
    tbl[9] = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 2'd0, 1'b1, 32'h0};

    // Reset values, including ready held low until the first edge after release.
    apply_reset();
    #1;
    check("reset_out_valid", 72'(ov1), 72'(0));
    check("reset_occupancy", 72'(occ1), 72'(0));
    check("reset_in_ready_skid", 72'(rdy1), 72'(0));
    check("reset_out_pc", 72'(opc1), 72'(0));
    check("reset_in_ready_single", 72'(rdy0), 72'(1));
    @(posedge clk); @(negedge clk); #1;
    check("ready_after_release", 72'(rdy1), 72'(1));
    @(negedge clk);

    // Backpressure, ordered drain and flush in TWO.
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].fl, tbl[i].iv, tbl[i].ordy, mk(tbl[i].pc));
      #1;
      check($sformatf("tbl%0d_out_valid", i), 72'(ov1), 72'(tbl[i].ov));
      check($sformatf("tbl%0d_occupancy", i), 72'(occ1), 72'(tbl[i].occ));
      check($sformatf("tbl%0d_in_ready", i), 72'(rdy1), 72'(tbl[i].rdy));
      if (tbl[i].ov)
        check($sformatf("tbl%0d_bundle", i), 72'({opc1, odata1, obd1, oexec1}), 72'(mk(tbl[i].opc)));
      @(negedge clk);
    end

    // Streaming with out_ready=1: one-cycle lag, no bubbles, both variants.
    apply_reset();
    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      drive(1'b0, k < 8, 1'b1, mk(32'h0040_0000 + 32'(4 * k)));
      #1;
      check("stream_ready", 72'(rdy1), 72'(1));
      if (k > 0) begin
        check("stream_skid_pc", 72'({ov1, opc1}), 72'({1'b1, 32'h0040_0000 + 32'(4 * (k - 1))}));
        check("stream_single_pc", 72'({ov0, opc0}), 72'({1'b1, 32'h0040_0000 + 32'(4 * (k - 1))}));
      end
      @(negedge clk);
    end

    // Bundle with bd and nonzero exec survives a multi-cycle stall.
    apply_reset();
    @(negedge clk);
    b = '{pc: 32'h0000_0600, data: 32'hDEAD_BEEF, bd: 1'b1, exec: 4'hA};
    drive(1'b0, 1'b1, 1'b0, b);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, '0);
    repeat (3) @(negedge clk);
    #1;
    check("bundle_skid", 72'({ov1, opc1, odata1, obd1, oexec1}), 72'({1'b1, b}));
    check("bundle_single", 72'({ov0, opc0, odata0, obd0, oexec0}), 72'({1'b1, b}));

    // Single-entry variant with toggling out_ready: ready rule, no loss, no duplication.
    apply_reset();
    @(negedge clk);
    n = 0; d = 0;
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, 1'b1, (c % 2) == 0, mk(32'h0040_0000 + 32'(4 * n)));
      #1;
      check("toggle_ready", 72'(rdy0), 72'(!ov0 || out_ready));
      if (ov0 && out_ready) begin
        check("toggle_drain_pc", 72'(opc0), 72'(32'h0040_0000 + 32'(4 * d)));
        d++;
      end
      if (rdy0) n++;
      @(negedge clk);
    end
    check("toggle_accepts", 72'(n), 72'(6));
    check("toggle_drains", 72'(d), 72'(5));

    // Random traffic against queue models of capacity 2 (registered ready) and 1.
    apply_reset();
    @(negedge clk);
    q1.delete(); q0.delete();
    for (int c = 0; c < 400; c++) begin
      fl   = ($urandom % 16) == 0;
      iv   = ($urandom % 4) != 0;
      ordy = ($urandom % 3) != 0;
      b    = '{pc: $urandom, data: $urandom, bd: 1'($urandom), exec: 4'($urandom)};
      drive(fl, iv, ordy, b);
      #1;
      r1 = q1.size() < 2;
      r0 = (q0.size() == 0) || ordy;
      check("rnd_skid_ready", 72'(rdy1), 72'(r1));
      check("rnd_skid_occ", 72'(occ1), 72'(q1.size()));
      check("rnd_skid_valid", 72'(ov1), 72'(q1.size() > 0));
      if (q1.size() > 0) check("rnd_skid_head", 72'({opc1, odata1, obd1, oexec1}), 72'(q1[0]));
      check("rnd_single_ready", 72'(rdy0), 72'(r0));
      check("rnd_single_occ", 72'(occ0), 72'(q0.size()));
      if (q0.size() > 0) check("rnd_single_head", 72'({opc0, odata0, obd0, oexec0}), 72'(q0[0]));
      @(posedge clk);
      if (fl) begin
        q1.delete(); q0.delete();
      end else begin
        if (q1.size() > 0 && ordy) void'(q1.pop_front());
        if (iv && r1) q1.push_back(b);
        if (q0.size() > 0 && ordy) void'(q0.pop_front());
        if (iv && r0) q0.push_back(b);
      end
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
